// File: rtl/sine_gen.sv
// DDS sine generator: 32-bit carrier and tone accumulators, PRBS keying bit, and a
// three-stage pipeline (accumulators, ROM read, output) with AM/FM/PM/ASK/FSK/PSK.
module sine_gen #(
    parameter logic [31:0] MOD_INC0 = 32'd42950,
    parameter logic [31:0] MOD_INC1 = 32'd85899,
    parameter logic [31:0] MOD_INC2 = 32'd214748,
    parameter logic [31:0] MOD_INC3 = 32'd429497,
    parameter int unsigned FM_SHIFT = 12,
    parameter int unsigned BIT_DIV  = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  flag_mod,
    input  logic [31:0] freq_c,
    output logic [7:0]  out,
    output logic [7:0]  mod_m,
    output logic        mod_sk
);

    localparam int unsigned CntW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    typedef enum logic [2:0] {
        ModeCarrier, ModeAm, ModeFm, ModePm, ModeAsk, ModeFsk, ModePsk
    } mode_e;

    // Full-wave sine from a quarter table; the negative half mirrors 255 - q except at
    // index 128, where the rounded value is 128 rather than 127.
    function automatic logic [7:0] sine_lut(input logic [7:0] idx);
        logic [6:0] j;
        logic [7:0] q;
        j = idx[6:0];
        if (j > 7'd64) j = 7'(8'd128 - {1'b0, idx[6:0]});
        case (j)
            7'd0:  q = 8'd128; 7'd1:  q = 8'd131; 7'd2:  q = 8'd134; 7'd3:  q = 8'd137;
            7'd4:  q = 8'd140; 7'd5:  q = 8'd143; 7'd6:  q = 8'd146; 7'd7:  q = 8'd149;
            7'd8:  q = 8'd152; 7'd9:  q = 8'd155; 7'd10: q = 8'd158; 7'd11: q = 8'd162;
            7'd12: q = 8'd165; 7'd13: q = 8'd167; 7'd14: q = 8'd170; 7'd15: q = 8'd173;
            7'd16: q = 8'd176; 7'd17: q = 8'd179; 7'd18: q = 8'd182; 7'd19: q = 8'd185;
            7'd20: q = 8'd188; 7'd21: q = 8'd190; 7'd22: q = 8'd193; 7'd23: q = 8'd196;
            7'd24: q = 8'd198; 7'd25: q = 8'd201; 7'd26: q = 8'd203; 7'd27: q = 8'd206;
            7'd28: q = 8'd208; 7'd29: q = 8'd211; 7'd30: q = 8'd213; 7'd31: q = 8'd215;
            7'd32: q = 8'd218; 7'd33: q = 8'd220; 7'd34: q = 8'd222; 7'd35: q = 8'd224;
            7'd36: q = 8'd226; 7'd37: q = 8'd228; 7'd38: q = 8'd230; 7'd39: q = 8'd232;
            7'd40: q = 8'd234; 7'd41: q = 8'd235; 7'd42: q = 8'd237; 7'd43: q = 8'd238;
            7'd44: q = 8'd240; 7'd45: q = 8'd241; 7'd46: q = 8'd243; 7'd47: q = 8'd244;
            7'd48: q = 8'd245; 7'd49: q = 8'd246; 7'd50: q = 8'd248; 7'd51: q = 8'd249;
            7'd52: q = 8'd250; 7'd53: q = 8'd250; 7'd54: q = 8'd251; 7'd55: q = 8'd252;
            7'd56: q = 8'd253; 7'd57: q = 8'd253; 7'd58: q = 8'd254; 7'd59: q = 8'd254;
            7'd60: q = 8'd254; 7'd61: q = 8'd255; 7'd62: q = 8'd255; 7'd63: q = 8'd255;
            default: q = 8'd255;
        endcase
        if (!idx[7] || (idx[6:0] == 7'd0)) return q;
        return 8'd255 - q;
    endfunction

    logic [31:0]     acc_c_q, acc_c_d;
    logic [31:0]     acc_m_q, acc_m_d;
    logic [6:0]      lfsr_q, lfsr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      rom_q, rom_d;
    logic [7:0]      tone_q, tone_d;
    logic            sk1_q, sk1_d;
    logic [7:0]      out_q, out_d;
    logic [7:0]      mod_m_q, mod_m_d;

    mode_e             mode;
    logic              sk;
    logic [31:0]       inc, tone_inc, fm_dev;
    logic [7:0]        rom_addr, am_out;
    logic signed [8:0] m_off, s_off;
    logic signed [17:0] s_ext, t_ext, am_prod;

    always_comb begin
        mode = ModeCarrier;
        if (flag_mod[5:4] == 2'b10) begin
            case (flag_mod[3:2])
                2'b01:   mode = ModeAm;
                2'b10:   mode = ModeFm;
                2'b11:   mode = ModePm;
                default: mode = ModeCarrier;
            endcase
        end else if (flag_mod[5:4] == 2'b11) begin
            case (flag_mod[1:0])
                2'b00:   mode = ModeAsk;
                2'b01:   mode = ModeFsk;
                2'b10:   mode = ModePsk;
                default: mode = ModeCarrier;
            endcase
        end
    end

    always_comb begin
        sk     = lfsr_q[6];
        tone_d = sine_lut(acc_m_q[31:24]);
        m_off  = $signed({1'b0, mod_m_q}) - 9'sd128;
        fm_dev = {{23{m_off[8]}}, m_off} << FM_SHIFT;

        case (mode)
            ModeFm:  inc = freq_c + fm_dev;
            ModeFsk: inc = sk ? {freq_c[30:0], 1'b0} : freq_c;
            default: inc = freq_c;
        endcase

        case (flag_mod[1:0])
            2'b00:   tone_inc = MOD_INC0;
            2'b01:   tone_inc = MOD_INC1;
            2'b10:   tone_inc = MOD_INC2;
            default: tone_inc = MOD_INC3;
        endcase

        acc_c_d = acc_c_q + inc;
        acc_m_d = acc_m_q + tone_inc;

        if (cnt_q == CntW'(BIT_DIV - 1)) begin
            cnt_d  = '0;
            lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end else begin
            cnt_d  = cnt_q + 1'b1;
            lfsr_d = lfsr_q;
        end

        case (mode)
            ModePm:  rom_addr = acc_c_q[31:24] + tone_d - 8'd128;
            ModePsk: rom_addr = acc_c_q[31:24] + {sk, 7'b0};
            default: rom_addr = acc_c_q[31:24];
        endcase
        rom_d = sine_lut(rom_addr);
        sk1_d = sk;

        // The floored product lies in -128..126, so its low byte plus 128 is exact.
        s_off   = $signed({1'b0, rom_q}) - 9'sd128;
        s_ext   = {{9{s_off[8]}}, s_off};
        t_ext   = {10'd0, tone_q};
        am_prod = s_ext * t_ext;
        am_out  = am_prod[15:8] + 8'd128;

        case (mode)
            ModeAm:  out_d = am_out;
            ModeAsk: out_d = sk1_q ? rom_q : 8'd128;
            default: out_d = rom_q;
        endcase

        case (mode)
            ModeAm, ModeFm, ModePm:    mod_m_d = tone_q;
            ModeAsk, ModeFsk, ModePsk: mod_m_d = sk1_q ? 8'hFF : 8'h00;
            default:                   mod_m_d = 8'd128;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_c_q <= '0;
            acc_m_q <= '0;
            lfsr_q  <= 7'h7F;
            cnt_q   <= '0;
            rom_q   <= 8'd128;
            tone_q  <= 8'd128;
            sk1_q   <= 1'b1;
            out_q   <= 8'd128;
            mod_m_q <= 8'd128;
        end else begin
            acc_c_q <= acc_c_d;
            acc_m_q <= acc_m_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            rom_q   <= rom_d;
            tone_q  <= tone_d;
            sk1_q   <= sk1_d;
            out_q   <= out_d;
            mod_m_q <= mod_m_d;
        end
    end

    assign out    = out_q;
    assign mod_m  = mod_m_q;
    assign mod_sk = lfsr_q[6];

endmodule

// File: tb/tb_sine_gen.sv
// Bench for sine_gen: a cycle-level reference built from the sine formula, the keying
// recurrence and phase arithmetic, driven with directed and random mode/frequency segments.
module tb_sine_gen;

    localparam int          BD  = 50;
    localparam int          FMS = 12;
    localparam logic [31:0] MI0 = 32'd4295000;
    localparam logic [31:0] MI1 = 32'd8589900;
    localparam logic [31:0] MI2 = 32'd21474800;
    localparam logic [31:0] MI3 = 32'd42949700;
    localparam real         PI  = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  flag_mod;
    logic [31:0] freq_c;
    logic [7:0]  out;
    logic [7:0]  mod_m;
    logic        mod_sk;

    int total = 0;
    int bad   = 0;

    int lut_t [256];
    bit seq [2048];

    logic [31:0] m_acc_c, m_acc_m;
    int          m_edges, m_rom, m_tone, m_sk1, m_out, m_modm;
    logic        m_sk;

    always #5 clk = ~clk;

    sine_gen #(
        .MOD_INC0 (MI0),
        .MOD_INC1 (MI1),
        .MOD_INC2 (MI2),
        .MOD_INC3 (MI3),
        .FM_SHIFT (FMS),
        .BIT_DIV  (BD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flag_mod (flag_mod),
        .freq_c   (freq_c),
        .out      (out),
        .mod_m    (mod_m),
        .mod_sk   (mod_sk)
    );

    // 0 carrier, 1 AM, 2 FM, 3 PM, 4 ASK, 5 FSK, 6 PSK
    function automatic int mode_of(input logic [5:0] f);
        if (f[5:4] == 2'b10) return (f[3:2] == 2'b00) ? 0 : int'(f[3:2]);
        if (f[5:4] == 2'b11) return (f[1:0] == 2'b11) ? 0 : 4 + int'(f[1:0]);
        return 0;
    endfunction

    function automatic logic [31:0] tone_step(input logic [1:0] s);
        case (s)
            2'd0:    return MI0;
            2'd1:    return MI1;
            2'd2:    return MI2;
            default: return MI3;
        endcase
    endfunction

    // One clock edge: advance the reference with the inputs currently applied, then sample.
    task automatic tick();
        int          md, sk, a, p, n_rom, n_tone, n_out, n_modm;
        logic [31:0] inc;
        if (rst) begin
            m_acc_c = 0; m_acc_m = 0; m_edges = 0;
            m_rom = 128; m_tone = 128; m_sk1 = 1; m_out = 128; m_modm = 128;
        end else begin
            md  = mode_of(flag_mod);
            sk  = int'(seq[m_edges / BD]);
            inc = freq_c;
            if (md == 2) inc = freq_c + 32'((m_modm - 128) * (1 << FMS));
            if (md == 5 && sk == 1) inc = freq_c + freq_c;
            a = int'(m_acc_c[31:24]);
            if (md == 3) a = (a + lut_t[m_acc_m[31:24]] - 128 + 256) % 256;
            if (md == 6) a = (a + 128 * sk) % 256;
            n_rom  = lut_t[a];
            n_tone = lut_t[m_acc_m[31:24]];
            p      = (m_rom - 128) * m_tone;
            case (md)
                1:       n_out = 128 + ((p >= 0) ? p / 256 : -((-p + 255) / 256));
                4:       n_out = (m_sk1 == 1) ? m_rom : 128;
                default: n_out = m_rom;
            endcase
            if (md >= 1 && md <= 3)      n_modm = m_tone;
            else if (md >= 4)            n_modm = (m_sk1 == 1) ? 255 : 0;
            else                         n_modm = 128;
            m_acc_c = m_acc_c + inc;
            m_acc_m = m_acc_m + tone_step(flag_mod[1:0]);
            m_rom = n_rom; m_tone = n_tone; m_sk1 = sk; m_out = n_out; m_modm = n_modm;
            m_edges++;
        end
        m_sk = seq[m_edges / BD];
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        flag_mod = 6'd0;
        freq_c   = 32'd0;
        rst      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (out !== 8'd128 || mod_m !== 8'd128 || mod_sk !== 1'b1) begin
                bad++;
                $display("FAIL reset out=%0d mod_m=%0d mod_sk=%0b expected 128/128/1",
                         out, mod_m, mod_sk);
            end
            total++;
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out !== 8'd128 || mod_m !== 8'd128) begin
                bad++;
                $display("FAIL frozen cyc=%0d out=%0d mod_m=%0d expected 128/128", i, out, mod_m);
            end
            total++;
        end
    endtask

    task automatic test_carrier();
        int mx = 0, mn = 255;
        flag_mod = 6'd0;
        freq_c   = 32'd42949673;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (out !== 8'(m_out) || mod_m !== 8'(m_modm) || mod_sk !== m_sk) begin
                bad++;
                $display("FAIL carrier cyc=%0d out=%0d exp %0d mod_m=%0d exp %0d",
                         i, out, m_out, mod_m, m_modm);
            end
            total++;
            if (i > 10 && int'(out) > mx) mx = int'(out);
            if (i > 10 && int'(out) < mn) mn = int'(out);
        end
        if (mx < 253 || mn > 2) begin
            bad++;
            $display("FAIL carrier_swing max=%0d min=%0d expected >=253 and <=2", mx, mn);
        end
        total++;
    endtask

    task automatic test_ask();
        flag_mod = 6'b11_0000;
        freq_c   = 32'd171798692;
        apply_reset();
        for (int i = 1; i <= 12 * BD; i++) begin
            tick();
            if (out !== 8'(m_out) || mod_m !== 8'(m_modm) || mod_sk !== m_sk) begin
                bad++;
                $display("FAIL ask cyc=%0d out=%0d exp %0d mod_m=%0d exp %0d sk=%0b exp %0b",
                         i, out, m_out, mod_m, m_modm, mod_sk, m_sk);
            end
            total++;
            if (i == 7 * BD - 1 && mod_sk !== 1'b1) begin
                bad++;
                $display("FAIL ask_last_one mod_sk=%0b expected 1", mod_sk);
            end
            if (i == 7 * BD - 1) total++;
            if (i == 7 * BD && mod_sk !== 1'b0) begin
                bad++;
                $display("FAIL ask_first_zero mod_sk=%0b expected 0", mod_sk);
            end
            if (i == 7 * BD) total++;
            if (m_modm == 0 && out !== 8'd128) begin
                bad++;
                $display("FAIL ask_off cyc=%0d out=%0d expected 128", i, out);
            end
            if (m_modm == 0) total++;
        end
    endtask

    task automatic test_mode(input logic [5:0] f, input logic [31:0] fc, input int n);
        flag_mod = f;
        freq_c   = fc;
        for (int i = 0; i < n; i++) begin
            tick();
            if (out !== 8'(m_out) || mod_m !== 8'(m_modm) || mod_sk !== m_sk) begin
                bad++;
                $display("FAIL mode_%b cyc=%0d out=%0d exp %0d mod_m=%0d exp %0d sk=%0b exp %0b",
                         f, i, out, m_out, mod_m, m_modm, mod_sk, m_sk);
            end
            total++;
        end
    endtask

    task automatic test_am_reset();
        int hi = 0, lo = 255;
        flag_mod = 6'b10_0101;
        freq_c   = 32'd214748365;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (out !== 8'(m_out) || mod_m !== 8'(m_modm)) begin
                bad++;
                $display("FAIL am cyc=%0d out=%0d exp %0d mod_m=%0d exp %0d",
                         i, out, m_out, mod_m, m_modm);
            end
            total++;
            if (m_modm >= 250 && int'(out) > hi) hi = int'(out);
            if (m_modm >= 250 && int'(out) < lo) lo = int'(out);
            if (m_modm <= 5 && (out < 8'd125 || out > 8'd130)) begin
                bad++;
                $display("FAIL am_collapse cyc=%0d out=%0d expected 125..130", i, out);
            end
            if (m_modm <= 5) total++;
        end
        if (hi < 230 || lo > 25) begin
            bad++;
            $display("FAIL am_envelope peak=%0d trough=%0d expected >=230 and <=25", hi, lo);
        end
        total++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (out !== 8'd128 || mod_m !== 8'd128 || mod_sk !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset out=%0d mod_m=%0d mod_sk=%0b expected 128/128/1",
                     out, mod_m, mod_sk);
        end
        total++;
        test_mode(6'b10_0101, 32'd214748365, 200);
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 16; seg++) begin
            flag_mod = 6'($urandom_range(0, 63));
            freq_c   = $urandom;
            rst      = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < 200; i++) begin
                tick();
                rst = 1'b0;
                if (out !== 8'(m_out) || mod_m !== 8'(m_modm) || mod_sk !== m_sk) begin
                    bad++;
                    $display("FAIL random seg=%0d flag=%b cyc=%0d out=%0d exp %0d mod_m=%0d exp %0d",
                             seg, flag_mod, i, out, m_out, mod_m, m_modm);
                end
                total++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            lut_t[i] = int'(127.5 + 127.5 * $sin(2.0 * PI * real'(i) / 256.0));
        for (int k = 0; k < 7; k++) seq[k] = 1'b1;
        for (int k = 0; k + 7 < 2048; k++) seq[k + 7] = seq[k] ^ seq[k + 1];
        rst      = 1'b1;
        flag_mod = 6'd0;
        freq_c   = 32'd0;

        test_reset();
        test_carrier();
        test_ask();
        test_mode(6'b11_0001, 32'd42949673, 600);
        test_mode(6'b10_1010, 32'd42949673, 1000);
        test_mode(6'b10_1110, 32'd85899346, 500);
        test_mode(6'b11_0010, 32'd42949673, 500);
        test_mode(6'b11_0011, 32'd0, 100);
        test_am_reset();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
